// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Shared defaults and types for the fully-connected input path.
//   FC_WIDTH     : activation width presented to the FC layer
//   FC_IN        : activations per frame
//   FC_IN_WIDTH  : width of the incoming (pre-requantization) activation
//   FC_SHIFT     : requantization right-shift amount
//   fc_act_t     : one requantized activation
//   fc_bank_sel_t: selects one of the two ping-pong banks
// ---------------------------------------------------------------------------
package fc_pkg;

  localparam int FC_WIDTH    = 8;
  localparam int FC_IN       = 128;
  localparam int FC_IN_WIDTH = 23;
  localparam int FC_SHIFT    = 7;

  typedef logic [FC_WIDTH-1:0] fc_act_t;
  typedef logic                fc_bank_sel_t;

endpackage

// File: rtl/fc_requant.sv
// ---------------------------------------------------------------------------
// fc_requant
// Combinational requantizer: wide signed activation -> WIDTH-bit unsigned.
// Negative inputs clamp to 0; positive inputs are shifted right by SHIFT and
// saturated to 2^(WIDTH-1)-1.
// Build option: define FC_IN_ROUND_EN to round half-up before the shift;
// otherwise the shift truncates.
// Ports:
//   i_data : incoming activation, signed two's complement, IN_WIDTH bits
//   o_q    : requantized activation, WIDTH bits
// ---------------------------------------------------------------------------
module fc_requant #(
  parameter int WIDTH    = 8,
  parameter int IN_WIDTH = 23,
  parameter int SHIFT    = 7
) (
  input  logic signed [IN_WIDTH-1:0] i_data,
  output logic        [WIDTH-1:0]    o_q
);

  // Largest positive value representable in the signed WIDTH-bit range.
  localparam logic signed [IN_WIDTH:0] MAXV =
    {{(IN_WIDTH+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};

`ifdef FC_IN_ROUND_EN
  localparam logic signed [IN_WIDTH:0] HALF =
    {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT-1);
`endif

  // One guard bit so the rounding add cannot wrap the sign.
  logic signed [IN_WIDTH:0] w_ext;
  logic signed [IN_WIDTH:0] w_t;

  always_comb begin
    w_ext = {i_data[IN_WIDTH-1], i_data};
`ifdef FC_IN_ROUND_EN
    w_ext = w_ext + HALF;
`endif
    w_t = w_ext >>> SHIFT;

    if (i_data[IN_WIDTH-1]) begin
      o_q = '0;
    end else if (w_t > MAXV) begin
      o_q = MAXV[WIDTH-1:0];
    end else begin
      o_q = w_t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fc_in_collect.sv
// ---------------------------------------------------------------------------
// fc_in_collect
// Ping-pong input collector for the FC layer. Requantizes one incoming
// activation per cycle and packs IN of them into a bank; two banks let the
// next frame fill while the presented one is held for the consumer.
// Build option: FC_IN_ROUND_EN (passed through to fc_requant) selects
// round-half-up requantization; undefined means truncation.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   in_data  : incoming signed activation
//   in_valid : in_data valid
//   in_ready : collector accepts in_data this cycle
//   x        : parallel frame [0:IN-1] to the layer, straight from registers
//   x_valid  : x holds a complete frame
//   x_ready  : consumer releases the presented frame
// ---------------------------------------------------------------------------
module fc_in_collect
  import fc_pkg::*;
#(
  parameter int WIDTH    = FC_WIDTH,
  parameter int IN       = FC_IN,
  parameter int IN_WIDTH = FC_IN_WIDTH,
  parameter int SHIFT    = FC_SHIFT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic        [WIDTH-1:0]    x [0:IN-1],
  output logic                       x_valid,
  input  logic                       x_ready
);

  localparam int IDX_W = $clog2(IN);

  logic [WIDTH-1:0] r_bank [2][IN];
  logic [1:0]       r_full;
  fc_bank_sel_t     r_wr_sel;
  fc_bank_sel_t     r_rd_sel;
  logic [IDX_W-1:0] r_wr_idx;

  logic [WIDTH-1:0] w_q;
  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic [1:0]       w_full_next;

  fc_requant #(
    .WIDTH    (WIDTH),
    .IN_WIDTH (IN_WIDTH),
    .SHIFT    (SHIFT)
  ) u_requant (
    .i_data (in_data),
    .o_q    (w_q)
  );

  assign in_ready  = !r_full[r_wr_sel];
  assign x_valid   = r_full[r_rd_sel];
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_wr_idx == IDX_W'(IN-1));
  assign w_release = x_valid && x_ready;

  // A completing bank is always empty and a released bank always full, so
  // the two updates never target the same bank and can both apply.
  always_comb begin
    w_full_next = r_full;
    if (w_release) begin
      w_full_next[r_rd_sel] = 1'b0;
    end
    if (w_accept && w_last) begin
      w_full_next[r_wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_idx <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < IN; i++) begin
          r_bank[b][i] <= '0;
        end
      end
    end else begin
      r_full <= w_full_next;
      if (w_accept) begin
        r_bank[r_wr_sel][r_wr_idx] <= w_q;
        if (w_last) begin
          r_wr_idx <= '0;
          r_wr_sel <= ~r_wr_sel;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_release) begin
        r_rd_sel <= ~r_rd_sel;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < IN; gi++) begin : g_x
      assign x[gi] = r_bank[r_rd_sel][gi];
    end
  endgenerate

endmodule
